// File: rtl/icache_pkg.sv
// icache_pkg: refill state encoding, derived-width helpers and address field extractors
// shared by the instruction cache top and its way-selection logic.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } icache_state_e;

    // Number of 32-bit words held by one line.
    function automatic int calc_line_words(input int line_width);
        return 1 << (line_width - 2);
    endfunction

    // Tag bits left above the set index and line offset.
    function automatic int calc_tag_width(input int line_width, input int set_width);
        return 32 - line_width - set_width;
    endfunction

    // A direct-mapped cache still carries a one-bit way index.
    function automatic int calc_way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Field extractors return right-aligned 32-bit values; callers keep the low bits.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int line_width,
                                             input int set_width);
        return addr >> (line_width + set_width);
    endfunction

    function automatic logic [31:0] addr_set(input logic [31:0] addr, input int line_width,
                                             input int set_width);
        return (addr >> line_width) & ((32'd1 << set_width) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int line_width);
        return (addr >> 2) & ((32'd1 << (line_width - 2)) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_line(input logic [31:0] addr, input int line_width);
        return addr >> line_width;
    endfunction

endpackage

// File: rtl/icache_way_sel.sv
// icache_way_sel: combinational tag match over the ways of one set plus victim choice
// (lowest-index invalid way, otherwise the set's round-robin pointer).
module icache_way_sel
    import icache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int TAG_WIDTH = 22,
    parameter int WAY_WIDTH = 1
) (
    input  logic [WAYS-1:0]                set_valid_i,
    input  logic [WAYS-1:0][TAG_WIDTH-1:0] set_tags_i,
    input  logic [TAG_WIDTH-1:0]           lookup_tag_i,
    input  logic [WAY_WIDTH-1:0]           rr_ptr_i,
    output logic                           hit_o,
    output logic [WAY_WIDTH-1:0]           hit_way_o,
    output logic [WAY_WIDTH-1:0]           victim_way_o
);

    logic [WAYS-1:0] match;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign match[gi] = set_valid_i[gi] && (set_tags_i[gi] == lookup_tag_i);
        end
    endgenerate

    assign hit_o = |match;

    // Encode the matching way and pick a victim; descending scan lets the lowest index win.
    always_comb begin
        hit_way_o    = '0;
        victim_way_o = rr_ptr_i;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit_way_o = WAY_WIDTH'(w);
            end
            if (!set_valid_i[w]) begin
                victim_way_o = WAY_WIDTH'(w);
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with combinational hit path,
// single-request refill FSM, round-robin replacement and whole-cache flush.
// Optional performance counters (hitCount/missCount) are built when ICACHE_PERF_CNT_EN is defined.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int LINE_WIDTH = 4,
    parameter int SET_WIDTH  = 6,
    parameter int WAYS       = 2
) (
    input  logic                         clkIn,
    input  logic                         resetIn,
    input  logic                         flushIn,
    input  logic [31:0]                  instrAddrIn,
    input  logic                         instrReqIn,
    output logic                         instrOutValid,
    output logic [31:0]                  instrOut,
    output logic                         miss,
    output logic                         memReqValid,
    input  logic                         memReqReady,
    output logic [31-LINE_WIDTH:0]       memReqAddr,
    input  logic                         memRespValid,
    input  logic [8*(2**LINE_WIDTH)-1:0] memRespData
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                  hitCount,
    output logic [31:0]                  missCount
`endif
);

    localparam int LINE_WORDS  = calc_line_words(LINE_WIDTH);
    localparam int TAG_WIDTH   = calc_tag_width(LINE_WIDTH, SET_WIDTH);
    localparam int WAY_WIDTH   = calc_way_width(WAYS);
    localparam int WORD_IDX_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LINE_ADDR_W = 32 - LINE_WIDTH;
    localparam int LINE_BITS   = 8 * (2 ** LINE_WIDTH);
    localparam int SETS        = 2 ** SET_WIDTH;
    localparam int ENTRY_W     = SET_WIDTH + WAY_WIDTH;
    localparam int ENTRIES     = 2 ** ENTRY_W;

    // Address decode of the current fetch.
    logic [31:0]             tag_full, set_full, word_full, line_full;
    logic [TAG_WIDTH-1:0]    lookup_tag;
    logic [SET_WIDTH-1:0]    lookup_set;
    logic [WORD_IDX_W-1:0]   lookup_word;
    logic [LINE_ADDR_W-1:0]  lookup_line;
    logic                    unused_addr_bits;

    assign tag_full    = addr_tag(instrAddrIn, LINE_WIDTH, SET_WIDTH);
    assign set_full    = addr_set(instrAddrIn, LINE_WIDTH, SET_WIDTH);
    assign word_full   = addr_word(instrAddrIn, LINE_WIDTH);
    assign line_full   = addr_line(instrAddrIn, LINE_WIDTH);
    assign lookup_tag  = tag_full[TAG_WIDTH-1:0];
    assign lookup_set  = set_full[SET_WIDTH-1:0];
    assign lookup_word = word_full[WORD_IDX_W-1:0];
    assign lookup_line = line_full[LINE_ADDR_W-1:0];
    // Upper bits of the right-aligned fields are always zero.
    assign unused_addr_bits = ^{tag_full[31:TAG_WIDTH], set_full[31:SET_WIDTH],
                                word_full[31:WORD_IDX_W], line_full[31:LINE_ADDR_W]};

    // Storage, flat and indexed {set, way}.
    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
    logic [LINE_BITS-1:0] data_q   [ENTRIES];
    logic [WAY_WIDTH-1:0] rr_ptr_q [SETS];

    // Refill bookkeeping.
    icache_state_e          state_q;
    logic                   mem_req_valid_q;
    logic                   drop_q;
    logic [LINE_ADDR_W-1:0] pend_line_q;
    logic [WAY_WIDTH-1:0]   pend_way_q;
    logic [LINE_BITS-1:0]   fill_data_q;

    logic [SET_WIDTH-1:0]   pend_set;
    logic [TAG_WIDTH-1:0]   pend_tag;
    logic [ENTRY_W-1:0]     fill_idx;
    logic [WAY_WIDTH-1:0]   rr_cur, rr_next;

    assign pend_set = pend_line_q[SET_WIDTH-1:0];
    assign pend_tag = pend_line_q[LINE_ADDR_W-1:SET_WIDTH];
    assign fill_idx = {pend_set, pend_way_q};
    assign rr_cur   = rr_ptr_q[pend_set];
    assign rr_next  = (rr_cur == WAY_WIDTH'(WAYS - 1)) ? '0 : rr_cur + WAY_WIDTH'(1);

    // Per-way view of the addressed set.
    logic [WAYS-1:0]                set_valid;
    logic [WAYS-1:0][TAG_WIDTH-1:0] set_tags;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_set_view
            assign set_valid[gi] = valid_q[{lookup_set, WAY_WIDTH'(gi)}];
            assign set_tags[gi]  = tag_q[{lookup_set, WAY_WIDTH'(gi)}];
        end
    endgenerate

    logic                 way_hit;
    logic [WAY_WIDTH-1:0] hit_way, victim_way;

    icache_way_sel #(
        .WAYS      (WAYS),
        .TAG_WIDTH (TAG_WIDTH),
        .WAY_WIDTH (WAY_WIDTH)
    ) u_way_sel (
        .set_valid_i  (set_valid),
        .set_tags_i   (set_tags),
        .lookup_tag_i (lookup_tag),
        .rr_ptr_i     (rr_ptr_q[lookup_set]),
        .hit_o        (way_hit),
        .hit_way_o    (hit_way),
        .victim_way_o (victim_way)
    );

    // Hit path: zero-latency word select; blocked during FILL and for the line being refilled.
    logic [LINE_BITS-1:0] rd_line;
    logic [31:0]          rd_word;
    logic                 hit, pend_hit, start_refill;

    assign rd_line       = data_q[{lookup_set, hit_way}];
    assign rd_word       = rd_line[32*lookup_word +: 32];
    assign hit           = instrReqIn && way_hit;
    assign pend_hit      = (state_q == WAIT) && (lookup_line == pend_line_q);
    assign instrOutValid = hit && (state_q != FILL) && !pend_hit;
    assign instrOut      = hit ? rd_word : 32'd0;
    assign miss          = instrReqIn && !way_hit;
    assign start_refill  = (state_q == IDLE) && miss && !flushIn;
    assign memReqValid   = mem_req_valid_q;
    assign memReqAddr    = pend_line_q;

    // Refill FSM: request one line, wait for the response, then install it.
    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            state_q         <= IDLE;
            mem_req_valid_q <= 1'b0;
            drop_q          <= 1'b0;
            pend_line_q     <= '0;
            pend_way_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_refill) begin
                        state_q         <= REQ;
                        mem_req_valid_q <= 1'b1;
                        drop_q          <= 1'b0;
                        pend_line_q     <= lookup_line;
                        pend_way_q      <= victim_way;
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        state_q         <= WAIT;
                        mem_req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (memRespValid) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // A flush while a refill is outstanding must keep that line from becoming valid.
            if (flushIn && ((state_q == REQ) || (state_q == WAIT))) begin
                drop_q <= 1'b1;
            end
        end
    end

    // Valid bits and round-robin pointers; flush overrides a same-cycle install.
    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr_q[s] <= '0;
            end
        end else begin
            if (state_q == FILL) begin
                rr_ptr_q[pend_set] <= rr_next;
                if (!drop_q && !flushIn) begin
                    valid_q[fill_idx] <= 1'b1;
                end
            end
            if (flushIn) begin
                valid_q <= '0;
            end
        end
    end

    // Line data capture and tag/data array writes (no reset needed, gated by valid bits).
    always_ff @(posedge clkIn) begin
        if ((state_q == WAIT) && memRespValid) begin
            fill_data_q <= memRespData;
        end
        if (state_q == FILL) begin
            data_q[fill_idx] <= fill_data_q;
            tag_q[fill_idx]  <= pend_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Free-running hit/miss counters; only reset clears them.
    always_ff @(posedge clkIn) begin
        if (!resetIn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (instrOutValid) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (start_refill) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed, self-checking bench for icache_assoc at default parameters.
// Expected fetch words are queued when a fetch is driven and popped when the cache returns data.
// Build with ICACHE_PERF_CNT_EN defined to also exercise the performance counters.
module tb_icache_assoc;

    logic         clkIn = 1'b0;
    logic         resetIn;
    logic         flushIn;
    logic [31:0]  instrAddrIn;
    logic         instrReqIn;
    logic         instrOutValid;
    logic [31:0]  instrOut;
    logic         miss;
    logic         memReqValid;
    logic         memReqReady;
    logic [27:0]  memReqAddr;
    logic         memRespValid;
    logic [127:0] memRespData;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hitCount;
    logic [31:0]  missCount;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clkIn = ~clkIn;

    icache_assoc dut (
        .clkIn         (clkIn),
        .resetIn       (resetIn),
        .flushIn       (flushIn),
        .instrAddrIn   (instrAddrIn),
        .instrReqIn    (instrReqIn),
        .instrOutValid (instrOutValid),
        .instrOut      (instrOut),
        .miss          (miss),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memReqAddr    (memReqAddr),
        .memRespValid  (memRespValid),
        .memRespData   (memRespData)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hitCount      (hitCount),
        .missCount     (missCount)
`endif
    );

    // Backing-store model: every word is derived from its line address and index.
    function automatic logic [31:0] mem_word(input logic [27:0] la, input int k);
        if (la == 28'h0000100 && k == 1) return 32'hDEADBEEF;
        return {4'hC, la[19:0], 6'd0, 2'(k)};
    endfunction

    function automatic logic [127:0] mk_line(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la, k);
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        return mem_word(addr[31:4], int'(addr[3:2]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Compare the fetch port; on a valid fetch pop the scoreboard entry.
    task automatic expect_out(input string tag, input bit exp_valid);
        logic [31:0] e;
        chk({tag, "_valid"}, 32'(instrOutValid), 32'(exp_valid));
        if (exp_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
            chk({tag, "_data"}, instrOut, e);
        end else begin
            chk({tag, "_zero"}, instrOut, 32'd0);
        end
    endtask

    // Advance to just after the next rising edge and release one-cycle pulses.
    task automatic tick();
        @(posedge clkIn);
        #1;
        flushIn      = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespData  = '0;
    endtask

    // One-cycle lookup; the request is withdrawn before the edge so no refill starts.
    task automatic probe(input logic [31:0] addr, input bit exp_hit);
        tick();
        instrAddrIn = addr;
        instrReqIn  = 1'b1;
        if (exp_hit) exp_q.push_back(exp_word(addr));
        #2;
        $display("probe addr=0x%08h exp_hit=%0d miss=%0d valid=%0d data=0x%08h",
                 addr, exp_hit, miss, instrOutValid, instrOut);
        chk($sformatf("probe_miss_%08h", addr), 32'(miss), 32'(!exp_hit));
        expect_out($sformatf("probe_%08h", addr), exp_hit);
        instrReqIn = 1'b0;
    endtask

    // Full miss/refill transaction; ends inside the FILL cycle.
    // flush_at: 0 none, 1 first WAIT cycle, 2 FILL cycle. hum_addr != 0 fetches it during WAIT.
    task automatic refill(input logic [31:0] addr, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] hum_addr, input int flush_at);
        logic [27:0] la;
        la = addr[31:4];
        tick();
        instrAddrIn = addr;
        instrReqIn  = 1'b1;
        #2;
        chk("refill_miss", 32'(miss), 32'd1);
        expect_out("refill_miss_out", 1'b0);
        tick();
        #2;
        chk("req_valid", 32'(memReqValid), 32'd1);
        chk("req_addr", {4'h0, memReqAddr}, {4'h0, la});
        for (int i = 1; i < rdy_dly; i++) begin
            tick();
            #2;
            chk("req_hold", 32'(memReqValid), 32'd1);
            chk("req_stable", {4'h0, memReqAddr}, {4'h0, la});
        end
        tick();
        memReqReady = 1'b1;
        #2;
        chk("req_hs_valid", 32'(memReqValid), 32'd1);
        tick();
        if (flush_at == 1) flushIn = 1'b1;
        #2;
        chk("req_done", 32'(memReqValid), 32'd0);
        if (hum_addr != 32'd0) begin
            instrAddrIn = hum_addr;
            exp_q.push_back(exp_word(hum_addr));
            #1;
            expect_out("hit_under_miss", 1'b1);
        end
        for (int i = 1; i < rsp_dly; i++) tick();
        tick();
        memRespValid = 1'b1;
        memRespData  = mk_line(la);
        instrReqIn   = 1'b0;
        tick();
        if (flush_at == 2) flushIn = 1'b1;
        instrReqIn = 1'b1;
        #2;
        chk("fill_blocked", 32'(instrOutValid), 32'd0);
        chk("fill_no_req", 32'(memReqValid), 32'd0);
        instrReqIn = 1'b0;
        $display("refill line=0x%07h done flush_at=%0d", la, flush_at);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetIn      = 1'b0;
        flushIn      = 1'b0;
        instrAddrIn  = '0;
        instrReqIn   = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespData  = '0;
        repeat (3) tick();
        resetIn = 1'b1;
        #2;
        chk("rst_req_valid", 32'(memReqValid), 32'd0);
        chk("rst_out_valid", 32'(instrOutValid), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        chk("rst_hit_cnt", hitCount, 32'd0);
        chk("rst_miss_cnt", missCount, 32'd0);
`endif
        probe(32'h0000_1004, 1'b0);

        // 1: cold fetch, ready after 3 cycles, response 2 cycles later
        refill(32'h0000_1004, 3, 2, 32'd0, 0);
        probe(32'h0000_1004, 1'b1);
        probe(32'h0000_100C, 1'b1);

        // 2: fill set 0 with two lines, third evicts way 0
        refill(32'h0000_2000, 1, 1, 32'd0, 0);
        probe(32'h0000_2000, 1'b1);
        probe(32'h0000_1000, 1'b1);
        refill(32'h0000_3000, 2, 1, 32'd0, 0);
        probe(32'h0000_2000, 1'b1);
        probe(32'h0000_1000, 1'b0);
        probe(32'h0000_3000, 1'b1);

        // 3: refill 0x1000 (evicts 0x2000 by round robin), then hit-under-miss
        refill(32'h0000_1000, 1, 1, 32'd0, 0);
        probe(32'h0000_3000, 1'b1);
        probe(32'h0000_2000, 1'b0);
        refill(32'h0000_5010, 1, 2, 32'h0000_1008, 0);
        probe(32'h0000_5010, 1'b1);
        probe(32'h0000_1008, 1'b1);

        // 4: flush during WAIT drops the refill and all prior lines
        refill(32'h0000_4000, 2, 1, 32'd0, 1);
        probe(32'h0000_4000, 1'b0);
        probe(32'h0000_1000, 1'b0);
        probe(32'h0000_3000, 1'b0);
        probe(32'h0000_5010, 1'b0);
        refill(32'h0000_4000, 1, 1, 32'd0, 0);
        probe(32'h0000_4000, 1'b1);
        // flush coincident with FILL wins
        refill(32'h0000_8000, 1, 1, 32'd0, 2);
        probe(32'h0000_8000, 1'b0);
        probe(32'h0000_4000, 1'b0);
        refill(32'h0000_4000, 1, 1, 32'd0, 0);
        probe(32'h0000_4000, 1'b1);

        // 5: reset in REQ, stray response afterwards
        tick();
        instrAddrIn = 32'h0000_7000;
        instrReqIn  = 1'b1;
        #2;
        chk("t5_miss", 32'(miss), 32'd1);
        tick();
        instrReqIn = 1'b0;
        #2;
        chk("t5_req", 32'(memReqValid), 32'd1);
        tick();
        resetIn = 1'b0;
        tick();
        resetIn = 1'b1;
        #2;
        chk("t5_req_dropped", 32'(memReqValid), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
        chk("t5_hit_cnt", hitCount, 32'd0);
        chk("t5_miss_cnt", missCount, 32'd0);
`endif
        tick();
        memRespValid = 1'b1;
        memRespData  = mk_line(28'h0000700);
        #2;
        chk("t5_stray_valid", 32'(instrOutValid), 32'd0);
        tick();
        #2;
        chk("t5_idle_req", 32'(memReqValid), 32'd0);
        probe(32'h0000_7000, 1'b0);
        probe(32'h0000_4000, 1'b0);
        refill(32'h0000_7000, 1, 1, 32'd0, 0);
        probe(32'h0000_7000, 1'b1);

`ifdef ICACHE_PERF_CNT_EN
        // 6: counters, 3 misses and 10 hit cycles, flush keeps counts
        tick();
        resetIn = 1'b0;
        tick();
        resetIn = 1'b1;
        #2;
        chk("t6_hit_cnt0", hitCount, 32'd0);
        chk("t6_miss_cnt0", missCount, 32'd0);
        refill(32'h0000_1000, 1, 1, 32'd0, 0);
        refill(32'h0000_2000, 1, 1, 32'd0, 0);
        refill(32'h0000_9010, 1, 1, 32'd0, 0);
        tick();
        #2;
        chk("t6_miss_cnt3", missCount, 32'd3);
        chk("t6_hit_cnt_pre", hitCount, 32'd0);
        instrAddrIn = 32'h0000_1004;
        instrReqIn  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exp_word(32'h0000_1004));
            #1;
            expect_out("t6_hit_cycle", 1'b1);
            tick();
        end
        instrReqIn = 1'b0;
        #2;
        $display("counters hit=%0d miss=%0d", hitCount, missCount);
        chk("t6_hit_cnt10", hitCount, 32'd10);
        chk("t6_miss_cnt", missCount, 32'd3);
        tick();
        flushIn = 1'b1;
        tick();
        #2;
        chk("t6_flush_hit_cnt", hitCount, 32'd10);
        chk("t6_flush_miss_cnt", missCount, 32'd3);
        probe(32'h0000_1004, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
